// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, pipelined in-order instruction memory requests,
// DEPTH-entry prefetch queue ahead of IF/ID; redirects drop stale responses via a 1-bit epoch tag.
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StallF,
  input  logic                       StallD,
  input  logic                       PCSrcD,
  input  logic [XLEN-1:0]            PCBranchD,
  output logic                       IReqValid,
  output logic [XLEN-1:0]            IReqAddr,
  input  logic                       IReqReady,
  input  logic                       IRespValid,
  input  logic [31:0]                IRespData,
  output logic [31:0]                InstrD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPD,
  output logic                       ValidD,
  output logic [$clog2(DEPTH+1)-1:0] QueueCount
);
  localparam int          QW  = $clog2(DEPTH + 1);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          FW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] r_pc;
  logic            r_epoch;

  logic [31:0]     r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [PW-1:0]   r_q_rd, r_q_wr;
  logic [QW-1:0]   r_q_cnt;

  logic            r_f_epoch [MAX_OUTSTANDING];
  logic [XLEN-1:0] r_f_pc    [MAX_OUTSTANDING];
  logic [FW-1:0]   r_f_rd, r_f_wr;
  logic [OW-1:0]   r_f_cnt;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pcd, r_pcpd;
  logic            r_validd;

  logic w_issue, w_accept, w_resp, w_keep, w_deq;

  // Credit: queue slots are reserved at issue time, so an in-flight response always has room.
  assign w_issue  = rst_n && !StallF && !PCSrcD &&
                    (int'(r_f_cnt) < MAX_OUTSTANDING) &&
                    ((int'(r_q_cnt) + int'(r_f_cnt)) < DEPTH);
  assign w_accept = w_issue && IReqReady;
  assign w_resp   = IRespValid && (r_f_cnt != '0);
  assign w_keep   = w_resp && (r_f_epoch[r_f_rd] == r_epoch) && !PCSrcD;
  assign w_deq    = !StallD && !PCSrcD && (r_q_cnt != '0);

  function automatic logic [FW-1:0] f_next(input logic [FW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + FW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_epoch <= 1'b0;
    end else if (PCSrcD) begin
      r_pc    <= {PCBranchD[XLEN-1:2], 2'b00};
      r_epoch <= ~r_epoch;
    end else if (w_accept) begin
      r_pc    <= r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rd  <= '0;
      r_f_wr  <= '0;
      r_f_cnt <= '0;
    end else begin
      if (w_accept) r_f_wr <= f_next(r_f_wr);
      if (w_resp)   r_f_rd <= f_next(r_f_rd);
      r_f_cnt <= r_f_cnt + OW'(w_accept) - OW'(w_resp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f_epoch[r_f_wr] <= r_epoch;
      r_f_pc[r_f_wr]    <= r_pc;
    end
    if (w_keep) begin
      r_q_instr[r_q_wr] <= IRespData;
      r_q_pc[r_q_wr]    <= r_f_pc[r_f_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_q_cnt <= '0;
    end else if (PCSrcD) begin
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_keep) r_q_wr <= r_q_wr + PW'(1);
      if (w_deq)  r_q_rd <= r_q_rd + PW'(1);
      r_q_cnt <= r_q_cnt + QW'(w_keep) - QW'(w_deq);
    end
  end

  // Bubbles keep the previous PCD/PCPD; only the instruction and valid bit change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= NOP;
      r_pcd    <= '0;
      r_pcpd   <= '0;
      r_validd <= 1'b0;
    end else if (PCSrcD) begin
      r_instr  <= NOP;
      r_validd <= 1'b0;
    end else if (!StallD) begin
      if (w_deq) begin
        r_instr  <= r_q_instr[r_q_rd];
        r_pcd    <= r_q_pc[r_q_rd];
        r_pcpd   <= r_q_pc[r_q_rd] + XLEN'(4);
        r_validd <= 1'b1;
      end else begin
        r_instr  <= NOP;
        r_validd <= 1'b0;
      end
    end
  end

  assign IReqValid  = w_issue;
  assign IReqAddr   = r_pc;
  assign InstrD     = r_instr;
  assign PCD        = r_pcd;
  assign PCPD       = r_pcpd;
  assign ValidD     = r_validd;
  assign QueueCount = r_q_cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model plus an in-order memory with variable latency.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, StallF, StallD, PCSrcD, IReqValid, IReqReady, IRespValid, ValidD;
  logic [31:0] PCBranchD, IReqAddr, IRespData, InstrD, PCD, PCPD;
  logic [2:0]  QueueCount;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
    .IRespValid(IRespValid), .IRespData(IRespData), .InstrD(InstrD), .PCD(PCD), .PCPD(PCPD),
    .ValidD(ValidD), .QueueCount(QueueCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        d_rst = 1'b0, d_stallf = 1'b0, d_stalld = 1'b0, d_pcsrc = 1'b0;
  logic [31:0] d_branch = '0;
  int          rdy_pct = 100;
  int          lat     = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  typedef struct packed { logic ep; logic [31:0] pc; } tag_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  tag_t        m_infl[$];
  ent_t        m_q[$];
  logic [31:0] m_pc, m_instr, m_pcd, m_pcpd;
  logic        m_ep, m_vld;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_infl.delete();
    m_q.delete();
    m_pc = '0; m_ep = 1'b0; m_instr = NOP; m_pcd = '0; m_pcpd = '0; m_vld = 1'b0;
  endtask

  task automatic check_and_advance();
    logic exp_vld, resp, keep;
    tag_t t;
    ent_t e;
    if (!rst_n) model_reset();
    exp_vld = rst_n && !StallF && !PCSrcD && (m_infl.size() < MAXO) &&
              ((m_q.size() + m_infl.size()) < DEPTH);
    chk("IReqValid", 32'(IReqValid), 32'(exp_vld));
    chk("IReqAddr", IReqAddr, m_pc);
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPD", PCPD, m_pcpd);
    chk("ValidD", 32'(ValidD), 32'(m_vld));
    chk("QueueCount", 32'(QueueCount), 32'(m_q.size()));
    if (rst_n) begin
      resp = IRespValid && (m_infl.size() > 0);
      t    = '0;
      if (resp) t = m_infl.pop_front();
      keep = resp && (t.ep == m_ep) && !PCSrcD;
      if (exp_vld && IReqReady) begin
        m_infl.push_back('{m_ep, m_pc});
        m_pc = m_pc + 32'd4;
      end
      if (PCSrcD) begin
        m_q.delete();
        m_ep = ~m_ep; m_pc = PCBranchD; m_instr = NOP; m_vld = 1'b0;
      end else begin
        if (!StallD) begin
          if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_instr = e.instr; m_pcd = e.pc; m_pcpd = e.pc + 32'd4; m_vld = 1'b1;
          end else begin
            m_instr = NOP; m_vld = 1'b0;
          end
        end
        if (keep) m_q.push_back('{IRespData, t.pc});
      end
    end
    if (IReqValid && IReqReady) begin
      mem_addr_q.push_back(IReqAddr);
      mem_due_q.push_back(cyc + lat);
    end
    chk("outstanding_max", 32'(mem_addr_q.size() <= MAXO), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst_n = d_rst; StallF = d_stallf; StallD = d_stalld; PCSrcD = d_pcsrc; PCBranchD = d_branch;
    IReqReady = ($urandom_range(0, 99) < rdy_pct);
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      IRespValid = 1'b1;
      IRespData  = mem_data(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      IRespValid = 1'b0;
      IRespData  = $urandom;
    end
    @(negedge clk);
    check_and_advance();
    cyc++;
  endtask

  initial begin
    int first, n, nv;
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    IReqReady = 1'b0; IRespValid = 1'b0; IRespData = '0;
    model_reset();
    repeat (3) step();
    chk("reset_InstrD", InstrD, NOP);
    chk("reset_IReqValid", 32'(IReqValid), 32'd0);

    // Free run after reset release with 1-cycle memory
    d_rst = 1'b1;
    step();
    chk("first_req_vld", 32'(IReqValid), 32'd1);
    chk("first_req_addr", IReqAddr, 32'h0);
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      step();
      if (ValidD) first = i + 1;
    end
    chk("valid_latency", 32'(first), 32'd3);
    chk("first_PCD", PCD, 32'h0);
    chk("first_PCPD", PCPD, 32'h4);
    step();
    chk("second_PCD", PCD, 32'h4);
    step();
    chk("third_PCD", PCD, 32'h8);
    chk("third_PCPD", PCPD, 32'hC);

    // Decode stall fills the queue
    d_stalld = 1'b1;
    repeat (10) step();
    chk("sat_count", 32'(QueueCount), 32'd4);
    chk("sat_noissue", 32'(IReqValid), 32'd0);
    d_stalld = 1'b0;
    repeat (6) step();

    // Redirect with two requests outstanding
    lat = 3;
    n = 0;
    while (mem_addr_q.size() != 2 && n < 20) begin step(); n++; end
    chk("two_outstanding", 32'(mem_addr_q.size()), 32'd2);
    d_pcsrc = 1'b1; d_branch = 32'h100;
    step();
    d_pcsrc = 1'b0;
    step();
    chk("redir_ValidD", 32'(ValidD), 32'd0);
    chk("redir_count", 32'(QueueCount), 32'd0);
    chk("redir_addr", IReqAddr, 32'h100);
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      step();
      if (ValidD) first = i;
    end
    chk("redir_found", 32'(first >= 0), 32'd1);
    chk("redir_PCD", PCD, 32'h100);

    // Ready toggling with 3-cycle latency
    rdy_pct = 50;
    repeat (40) step();
    rdy_pct = 100; lat = 1;

    // StallF with three queued entries drains to bubbles
    d_stallf = 1'b1; d_stalld = 1'b1;
    n = 0;
    while (mem_addr_q.size() != 0 && n < 20) begin step(); n++; end
    d_pcsrc = 1'b1; d_branch = 32'h200;
    step();
    d_pcsrc = 1'b0; d_stallf = 1'b0;
    repeat (3) step();
    d_stallf = 1'b1;
    step();
    step();
    chk("three_queued", 32'(QueueCount), 32'd3);
    d_stalld = 1'b0;
    nv = 0;
    repeat (6) begin
      step();
      nv += int'(ValidD);
      chk("drain_noissue", 32'(IReqValid), 32'd0);
    end
    chk("drain_count", 32'(nv), 32'd3);
    chk("drain_bubble", 32'(ValidD), 32'd0);

    // Reset pulse mid-burst
    d_stallf = 1'b0; lat = 3;
    repeat (5) step();
    d_rst = 1'b0;
    step();
    chk("midrst_ValidD", 32'(ValidD), 32'd0);
    chk("midrst_count", 32'(QueueCount), 32'd0);
    chk("midrst_issue", 32'(IReqValid), 32'd0);
    chk("midrst_PCD", PCD, 32'h0);
    step();
    d_rst = 1'b1; d_stallf = 1'b1;
    n = 0;
    while (mem_addr_q.size() != 0 && n < 20) begin step(); n++; end
    chk("stale_drained", 32'(mem_addr_q.size()), 32'd0);
    chk("stale_ignored", 32'(QueueCount), 32'd0);
    d_stallf = 1'b0;
    step();
    chk("restart_vld", 32'(IReqValid), 32'd1);
    chk("restart_addr", IReqAddr, 32'h0);
    repeat (10) step();

    // Randomized soak
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(1, 3));
      rdy_pct  = 70;
      d_stallf = ($urandom_range(0, 99) < 20);
      d_stalld = ($urandom_range(0, 99) < 25);
      d_pcsrc  = ($urandom_range(0, 99) < 5);
      d_branch = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue for the pipelined RISC-V core. It generates sequential PCs, issues pipelined requests to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a DEPTH-entry FIFO ahead of the IF/ID register. It is the successor of the single-register Fetch stage: same stall/redirect controls, plus multiple outstanding requests, a memory handshake and redirect-safe discard of stale responses.

## Interface

- XLEN, 32, address/PC width
- DEPTH, 4, prefetch queue entries (power of 2, >= 2)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..DEPTH)
- RESET_PC, 32'h0000_0000, PC after reset
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- StallF  input  1  hazard unit: suppress new request issue
- StallD  input  1  hazard unit: hold the IF/ID register
- PCSrcD  input  1  taken branch/jump resolved in decode: redirect
- PCBranchD  input  XLEN  redirect target
- IReqValid  output  1  request valid
- IReqAddr  output  XLEN  request address (word aligned)
- IReqReady  input  1  memory accepts request this cycle
- IRespValid  input  1  response valid (in request order, >= 1 cycle after accept)
- IRespData  input  32  returned instruction
- InstrD  output  32  IF/ID instruction
- PCD  output  XLEN  IF/ID instruction PC
- PCPD  output  XLEN  IF/ID PC+4
- ValidD  output  1  IF/ID holds a real instruction
- QueueCount  output  $clog2(DEPTH+1)  current queue occupancy

## Operation

- State: PC register; queue (DEPTH x {instr, pc}); in-flight FIFO (MAX_OUTSTANDING x {epoch, pc}); 1-bit epoch; IF/ID register.
- Issue: IReqValid = !StallF && !PCSrcD && outstanding < MAX_OUTSTANDING && (QueueCount + outstanding) < DEPTH. IReqAddr = PC. No hold requirement on memory side; request is per-cycle.
- Accept (IReqValid && IReqReady): push {epoch, PC} into in-flight FIFO; PC <= PC + 4 (mod 2^XLEN, wraps).
- Response: pop in-flight FIFO; if tag epoch == current epoch push {IRespData, tag pc} into queue, else discard. IRespValid with in-flight FIFO empty is ignored.
- Credit rule guarantees no queue overflow; in-order responses never reorder.
- IF/ID update when !StallD: queue non-empty -> load head, pop, ValidD=1, PCPD = pc+4; empty -> bubble (InstrD=32'h0000_0013, ValidD=0, PCD/PCPD hold).
- Redirect (PCSrcD=1), regardless of StallF/StallD: PC <= PCBranchD; queue cleared; epoch toggles; IF/ID flushed to bubble; no request issued that cycle; in-flight entries kept so their responses are counted and dropped.
- Simultaneous response and dequeue: both occur; QueueCount nets out. Response arriving in a redirect cycle is dropped (old epoch).

## Timing

- Reset (async assert, sync-safe deassert): PC=RESET_PC, queue and in-flight empty, epoch=0, InstrD=32'h0000_0013, PCD=0, PCPD=0, ValidD=0, QueueCount=0, IReqValid=0 while rst_n=0. Reset mid-transfer abandons all outstanding requests; later responses ignored.
- Min latency: request accepted cycle t, response t+1, in queue end of t+1, in IF/ID end of t+2. No response-to-IF/ID bypass.
- Redirect in cycle t: first request to PCBranchD issued cycle t+1; earliest valid IF/ID at end of t+3.
- Sustained throughput 1 instr/cycle with 1-cycle memory and MAX_OUTSTANDING >= 2.
- StallF affects issue only; queued instructions still drain to IF/ID.

## Test plan

- Reset then free-run, 1-cycle memory, IReqReady=1: IReqAddr 0,4,8,...; ValidD rises 3 cycles after reset release; PCD 0,4,8 back-to-back, PCPD=PCD+4.
- StallD held 10 cycles: QueueCount saturates at 4, IReqValid drops at QueueCount+outstanding=4, no loss; release -> PCD continues in sequence.
- PCSrcD=1 with PCBranchD=32'h100 while 2 requests outstanding: IF/ID bubble, QueueCount=0, both stale responses dropped, next ValidD instruction has PCD=32'h100.
- IReqReady toggling 0/1 with 3-cycle response latency: no duplicated or skipped PC; outstanding never exceeds 2.
- StallF=1 with queue holding 3 entries, StallD=0: 3 instructions drain, then bubbles, IReqValid=0 throughout.
- rst_n pulsed low mid-burst with responses in flight: outputs return to reset values immediately, post-reset responses ignored, fetch restarts at RESET_PC.
